falling_object_engine: RTL

- Parametrised successor to the single-object blue/green falling-object generators.
- Manages NUM_OBJ independent falling objects on a ROWS x COLS grid. Each object has its own fall period, and spawn columns come from a shared LFSR.
- Detects collision against the player column on-chip, replacing the ad-hoc touch compare in the top level.
- Sits between moveobject and the display multiplexer/HP logic; runs on the system clock with clock-enable style timing instead of derived clocks.

---
 rtl/falling_object_engine_pkg.sv | 25 ++
 rtl/falling_object_engine_fall_lane.sv | 86 ++++++++
 rtl/falling_object_engine.sv | 118 +++++++++++
 3 files changed

// File: rtl/falling_object_engine_pkg.sv
// Shared types and helpers for the falling-object engine and its per-object lanes.
package falling_obj_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FALL,
      LAND
   } obj_state_t;

   // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
   localparam int PERIOD_W = 32;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int k = 0; k < 8; k++) c = c + {3'b000, v[k]};
      return c;
   endfunction

endpackage

// File: rtl/falling_object_engine_fall_lane.sv
// One falling object: IDLE/FALL/LAND state, row-step period counter and player hit check.
module fall_lane
   import falling_obj_pkg::*;
#(
   parameter  int ROWS = 8,
   parameter  int COLS = 8,
   localparam int RW   = idx_w(ROWS),
   localparam int CW   = idx_w(COLS)
) (
   input  logic                CLK,
   input  logic                Clear,
   input  logic                pause,
   input  logic                grant,
   input  logic [CW-1:0]       spawn_col,
   input  logic [CW-1:0]       player_col,
   input  logic [PERIOD_W-1:0] period,
   output logic                idle,
   output logic                valid,
   output logic [RW-1:0]       row,
   output logic [CW-1:0]       col,
   output logic                hit_evt,
   output logic                land_evt,
   output logic                hit_pulse,
   output logic                land_pulse
);

   obj_state_t          state;
   logic [PERIOD_W-1:0] cnt;
   logic                at_term;
   logic                hit_now;

   // >= rather than == so a period shortened mid-count still steps on the next clock
   assign at_term  = (cnt >= period - 1'b1);
   assign hit_now  = (state == FALL) && (row >= RW'(ROWS - 2)) && (col == player_col);
   assign hit_evt  = !pause && hit_now;
   assign land_evt = !pause && (state == FALL) && !hit_now && at_term && (row == RW'(ROWS - 1));
   assign idle     = (state == IDLE);

   // NOTE: sequential state uses non-blocking assignments so every lane samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (Clear) begin
         state      <= IDLE;
         valid      <= 1'b0;
         row        <= '0;
         col        <= '0;
         cnt        <= '0;
         hit_pulse  <= 1'b0;
         land_pulse <= 1'b0;
      end else begin
         hit_pulse  <= hit_evt;
         land_pulse <= land_evt;
         if (!pause) begin
            case (state)
               IDLE: if (grant) begin
                  state <= FALL;
                  valid <= 1'b1;
                  row   <= '0;
                  col   <= spawn_col;
                  cnt   <= '0;
               end
               FALL: if (hit_now) begin
                  state <= IDLE;
                  valid <= 1'b0;
                  row   <= '0;
                  col   <= '0;
                  cnt   <= '0;
               end else if (at_term) begin
                  cnt <= '0;
                  if (row == RW'(ROWS - 1)) state <= LAND;
                  else                      row   <= row + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               LAND: begin
                  state <= IDLE;
                  valid <= 1'b0;
                  row   <= '0;
                  col   <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/falling_object_engine.sv
// NUM_OBJ falling objects with shared LFSR spawn columns, registered spawn arbiter and hit/land counters.
// Optional FOE_SPEEDUP_EN: a speed level bumped every 8th landing shortens every lane's period.
module falling_object_engine
   import falling_obj_pkg::*;
#(
   parameter  int         NUM_OBJ     = 2,
   parameter  int         ROWS        = 8,
   parameter  int         COLS        = 8,
   parameter  int         BASE_PERIOD = 5000000,
   parameter  int         PERIOD_STEP = 1000000,
   parameter  int         MIN_PERIOD  = 1000000,
   parameter  logic [7:0] LFSR_SEED   = 8'hA5,
   localparam int         RW          = idx_w(ROWS),
   localparam int         CW          = idx_w(COLS)
) (
   input  logic                  CLK,
   input  logic                  Clear,
   input  logic                  pause,
   input  logic [CW-1:0]         player_col,
   output logic [NUM_OBJ-1:0]    obj_valid,
   output logic [NUM_OBJ*RW-1:0] obj_row,
   output logic [NUM_OBJ*CW-1:0] obj_col,
   output logic [NUM_OBJ-1:0]    hit_pulse,
   output logic [NUM_OBJ-1:0]    land_pulse,
   output logic [3:0]            hit_count,
   output logic [7:0]            land_count
);

   logic [7:0]         lfsr;
   logic [CW-1:0]      spawn_col_q;
   logic [NUM_OBJ-1:0] idle, grant_q, grant_d, hit_evt, land_evt;
   logic [3:0]         hit_add, land_add;
   logic [4:0]         hit_sum;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant_d = '0;
      // pending grants are masked so a lane is never granted twice before it leaves IDLE
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (idle[i] && !grant_q[i]) begin
            grant_d    = '0;
            grant_d[i] = 1'b1;
         end
      end
      hit_add  = popcount(8'(hit_evt));
      land_add = popcount(8'(land_evt));
      hit_sum  = {1'b0, hit_count} + {1'b0, hit_add};
   end

   // NOTE: reset is synchronous and sampled on the clock edge, not in the sensitivity list.
   always_ff @(posedge CLK) begin
      if (Clear) begin
         lfsr        <= LFSR_SEED;
         grant_q     <= '0;
         spawn_col_q <= '0;
         hit_count   <= '0;
         land_count  <= '0;
      end else begin
         hit_count  <= hit_sum[4] ? 4'hF : hit_sum[3:0];
         land_count <= land_count + {4'b0000, land_add};
         if (!pause) begin
            lfsr        <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            grant_q     <= grant_d;
            spawn_col_q <= lfsr[CW-1:0];
         end
      end
   end

`ifdef FOE_SPEEDUP_EN
   logic [3:0] level;
   logic [3:0] land_wrap;

   assign land_wrap = {1'b0, land_count[2:0]} + land_add;

   always_ff @(posedge CLK) begin
      if (Clear)                            level <= '0;
      else if (land_wrap[3] && level != 4'hF) level <= level + 1'b1;
   end
`endif

   for (genvar g = 0; g < NUM_OBJ; g++) begin : g_lane
      localparam logic [PERIOD_W-1:0] NOM = PERIOD_W'(BASE_PERIOD + g * PERIOD_STEP);
      logic [PERIOD_W-1:0] period;

`ifdef FOE_SPEEDUP_EN
      logic [PERIOD_W+3:0] red;
      always_comb begin
         red    = (PERIOD_W+4)'(level) * (PERIOD_W+4)'(PERIOD_STEP);
         period = (red + (PERIOD_W+4)'(MIN_PERIOD) > (PERIOD_W+4)'(NOM)) ?
                  PERIOD_W'(MIN_PERIOD) : NOM - red[PERIOD_W-1:0];
      end
`else
      assign period = NOM;
`endif

      fall_lane #(
         .ROWS(ROWS),
         .COLS(COLS)
      ) u_lane (
         .CLK       (CLK),
         .Clear     (Clear),
         .pause     (pause),
         .grant     (grant_q[g]),
         .spawn_col (spawn_col_q),
         .player_col(player_col),
         .period    (period),
         .idle      (idle[g]),
         .valid     (obj_valid[g]),
         .row       (obj_row[g*RW +: RW]),
         .col       (obj_col[g*CW +: CW]),
         .hit_evt   (hit_evt[g]),
         .land_evt  (land_evt[g]),
         .hit_pulse (hit_pulse[g]),
         .land_pulse(land_pulse[g])
      );
   end

endmodule
